// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer: PRECHARGE-all, N_AREF auto-refreshes, mode register load, then DONE.
// Define SDRAM_AUTO_REFRESH_EN to issue periodic AREF every REF_INTERVAL enabled cycles in DONE.
module sdram_init_refresh #(
    parameter int T_PWRUP      = 10000,
    parameter int T_RP         = 3,
    parameter int T_RFC        = 9,
    parameter int T_MRD        = 2,
    parameter int N_AREF       = 2,
    parameter int CAS_LAT      = 3,
    parameter int BL_CODE      = 3,
    parameter int REF_INTERVAL = 780
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        ireq,
    input  logic        ienb,
    output logic        ofin,
    output logic        orefresh,
    output logic        DRAM_CKE,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic        DRAM_LDQM,
    output logic        DRAM_UDQM
);

    localparam int TM1   = (T_PWRUP > T_RP) ? T_PWRUP : T_RP;
    localparam int TM2   = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int T_MAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(T_RP - 1);
    localparam logic [CW-1:0] RFC_LAST = CW'(T_RFC - 1);
    localparam logic [CW-1:0] MRD_LAST = CW'(T_MRD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    AREF_LAST = 3'(N_AREF - 1);

    localparam logic [2:0]  CL_BITS   = 3'(CAS_LAT);
    localparam logic [2:0]  BL_BITS   = 3'(BL_CODE);
    localparam logic [12:0] MODE_WORD = {3'b000, 1'b0, 2'b00, CL_BITS, 1'b0, BL_BITS};

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_AREF    = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    if (N_AREF < 1 || N_AREF > 8 || REF_INTERVAL <= T_RFC) begin : g_bad_params
        $error("sdram_init_refresh: illegal N_AREF or REF_INTERVAL");
    end

    typedef enum logic [3:0] {
        IDLE, WAIT_PWR, PRECH, WAIT_RP, AREF, WAIT_RFC, LMR, WAIT_MRD, DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    aref_cnt, aref_cnt_d;
    logic [3:0]    cmd, cmd_d;
    logic [12:0]   addr_d;
    logic [1:0]    ba_d;
    logic          cke_d, fin_d, refr_d;

`ifdef SDRAM_AUTO_REFRESH_EN
    localparam int RW = $clog2(REF_INTERVAL) + 1;
    localparam logic [RW-1:0] REF_LAST     = RW'(REF_INTERVAL - 1);
    localparam logic [RW-1:0] REF_RFC_LAST = RW'(T_RFC - 1);
    logic [RW-1:0] ref_cnt, ref_cnt_d;
`endif

    assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd;

    // Outputs are registered from the current state, so each command appears one edge after its state is entered.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        aref_cnt_d = aref_cnt;
        cmd_d      = (state == IDLE) ? CMD_INHIBIT : CMD_NOP;
        addr_d     = '0;
        ba_d       = '0;
        cke_d      = DRAM_CKE;
        fin_d      = ofin;
`ifdef SDRAM_AUTO_REFRESH_EN
        refr_d     = orefresh;
        ref_cnt_d  = (state == DONE) ? ref_cnt : '0;
`else
        refr_d     = 1'b0;
`endif
        if (state == IDLE) begin
            cke_d  = 1'b0;
            fin_d  = 1'b0;
            refr_d = 1'b0;
            if (ireq && ienb) begin
                state_d    = WAIT_PWR;
                cnt_d      = '0;
                aref_cnt_d = '0;
            end
        end else if (ienb) begin
            cke_d = 1'b1;
            case (state)
                WAIT_PWR: begin
                    if (cnt == PWR_LAST) begin
                        state_d = PRECH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                PRECH: begin
                    cmd_d      = CMD_PRE;
                    addr_d[10] = 1'b1;
                    cnt_d      = CNT_ONE;
                    state_d    = (T_RP > 1) ? WAIT_RP : AREF;
                end
                WAIT_RP: begin
                    if (cnt == RP_LAST) begin
                        state_d = AREF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                AREF: begin
                    cmd_d = CMD_AREF;
                    cnt_d = CNT_ONE;
                    if (T_RFC > 1) begin
                        state_d = WAIT_RFC;
                    end else if (aref_cnt == AREF_LAST) begin
                        state_d = LMR;
                    end else begin
                        aref_cnt_d = aref_cnt + 3'd1;
                    end
                end
                WAIT_RFC: begin
                    if (cnt == RFC_LAST) begin
                        cnt_d = '0;
                        if (aref_cnt == AREF_LAST) begin
                            state_d = LMR;
                        end else begin
                            state_d    = AREF;
                            aref_cnt_d = aref_cnt + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                LMR: begin
                    cmd_d   = CMD_LMR;
                    addr_d  = MODE_WORD;
                    cnt_d   = CNT_ONE;
                    state_d = (T_MRD > 1) ? WAIT_MRD : DONE;
                end
                WAIT_MRD: begin
                    if (cnt == MRD_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                DONE: begin
                    fin_d = 1'b1;
`ifdef SDRAM_AUTO_REFRESH_EN
                    if (ref_cnt == REF_LAST) begin
                        cmd_d     = CMD_AREF;
                        refr_d    = 1'b1;
                        ref_cnt_d = '0;
                    end else begin
                        ref_cnt_d = ref_cnt + 1'b1;
                        refr_d    = orefresh && (ref_cnt < REF_RFC_LAST);
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            aref_cnt  <= '0;
            cmd       <= CMD_INHIBIT;
            DRAM_ADDR <= '0;
            DRAM_BA   <= '0;
            DRAM_CKE  <= 1'b0;
            ofin      <= 1'b0;
            orefresh  <= 1'b0;
            DRAM_LDQM <= 1'b1;
            DRAM_UDQM <= 1'b1;
`ifdef SDRAM_AUTO_REFRESH_EN
            ref_cnt   <= '0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            aref_cnt  <= aref_cnt_d;
            cmd       <= cmd_d;
            DRAM_ADDR <= addr_d;
            DRAM_BA   <= ba_d;
            DRAM_CKE  <= cke_d;
            ofin      <= fin_d;
            orefresh  <= refr_d;
            DRAM_LDQM <= 1'b1;
            DRAM_UDQM <= 1'b1;
`ifdef SDRAM_AUTO_REFRESH_EN
            ref_cnt   <= ref_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Testbench for sdram_init_refresh: schedule-based reference model plus pinned literal timings.
module tb_sdram_init_refresh;

    localparam int TP = 8, TRP = 2, TRFC = 4, TMRD = 2, NAR = 2, CL = 3, BL = 3, RI = 16;
    localparam int K_PRE   = TP + 1;
    localparam int K_AREF0 = K_PRE + TRP;
    localparam int K_LMR   = K_AREF0 + NAR * TRFC;
    localparam int K_DONE  = K_LMR + TMRD;

    localparam logic [3:0] C_INH = 4'hF, C_NOP = 4'h7, C_PRE = 4'h2, C_AREF = 4'h1, C_LMR = 4'h0;
    localparam logic [12:0] MODE = 13'h033;

    logic clk = 1'b0, ireset_n = 1'b0, ireq = 1'b0, ienb = 1'b0;
    logic ofin, orefresh, cke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [3:0]  dut_cmd;
    assign dut_cmd = {cs_n, ras_n, cas_n, we_n};

    sdram_init_refresh #(
        .T_PWRUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD), .N_AREF(NAR),
        .CAS_LAT(CL), .BL_CODE(BL), .REF_INTERVAL(RI)
    ) dut (
        .iclk(clk), .ireset_n(ireset_n), .ireq(ireq), .ienb(ienb),
        .ofin(ofin), .orefresh(orefresh), .DRAM_CKE(cke), .DRAM_ADDR(addr), .DRAM_BA(ba),
        .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n),
        .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, edge_no = 0;
    bit m_acc = 1'b0;
    int m_k = 0, acc_edge = 0, fin_rel = -1;
    int ev_rel[$];
    logic [3:0]  ev_cmd[$];
    logic [12:0] ev_addr[$];
    logic s_rst, s_req, s_enb;
    logic [3:0]  e_cmd;
    logic [12:0] e_addr;
    logic e_cke, e_fin, e_refr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
        end
    endtask

    // k = number of enabled edges since the accepting edge
    function automatic logic [3:0] exp_cmd(input int k);
        if (k == K_PRE) return C_PRE;
        for (int i = 0; i < NAR; i++)
            if (k == K_AREF0 + i * TRFC) return C_AREF;
        if (k == K_LMR) return C_LMR;
`ifdef SDRAM_AUTO_REFRESH_EN
        if (k >= K_DONE && ((k - K_DONE) % RI) == RI - 1) return C_AREF;
`endif
        return C_NOP;
    endfunction

    function automatic logic [12:0] exp_addr(input int k);
        if (k == K_PRE) return 13'h400;
        if (k == K_LMR) return MODE;
        return 13'h000;
    endfunction

    function automatic logic exp_refr(input int k);
`ifdef SDRAM_AUTO_REFRESH_EN
        int d;
        d = k - K_DONE;
        return (d >= RI - 1) && (((d - (RI - 1)) % RI) < TRFC);
`else
        return (k < 0);
`endif
    endfunction

    always @(posedge clk) begin
        s_rst = ireset_n;
        s_req = ireq;
        s_enb = ienb;
        #1;
        edge_no++;
        if (!s_rst || !m_acc) begin
            if (!s_rst) m_acc = 1'b0;
            e_cmd = C_INH; e_addr = '0; e_cke = 1'b0; e_fin = 1'b0; e_refr = 1'b0;
            if (s_rst && s_req && s_enb) begin
                m_acc = 1'b1; m_k = 0; acc_edge = edge_no; fin_rel = -1;
                ev_rel.delete(); ev_cmd.delete(); ev_addr.delete();
            end
        end else begin
            if (s_enb) m_k++;
            e_cmd  = s_enb ? exp_cmd(m_k) : C_NOP;
            e_addr = s_enb ? exp_addr(m_k) : 13'h000;
            e_cke  = (m_k >= 1);
            e_fin  = (m_k >= K_DONE);
            e_refr = exp_refr(m_k);
        end
        chk("cmd", 32'(dut_cmd), 32'(e_cmd));
        chk("addr", 32'(addr), 32'(e_addr));
        chk("ba", 32'(ba), 0);
        chk("cke", 32'(cke), 32'(e_cke));
        chk("ofin", 32'(ofin), 32'(e_fin));
        chk("orefresh", 32'(orefresh), 32'(e_refr));
        chk("dqm", 32'({ldqm, udqm}), 3);
        if (m_acc && edge_no != acc_edge) begin
            if (dut_cmd != C_NOP && dut_cmd != C_INH) begin
                ev_rel.push_back(edge_no - acc_edge);
                ev_cmd.push_back(dut_cmd);
                ev_addr.push_back(addr);
            end
            if (ofin === 1'b1 && fin_rel < 0) fin_rel = edge_no - acc_edge;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        ireset_n = 1'b0; ireq = 1'b0; ienb = 1'b0;
        @(negedge clk);
        ireset_n = 1'b1;
    endtask

    task automatic start_run();
        @(negedge clk);
        ireq = 1'b1; ienb = 1'b1; fin_rel = -1;
    endtask

    task automatic run_until_fin(input bit toggle, input bit keep_req, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fin_rel >= 0) break;
            ienb = toggle ? ~ienb : 1'b1;
            ireq = keep_req;
        end
        chk("fin_timeout", 32'(fin_rel >= 0), 1);
    endtask

    task automatic check_run(input int s);
        chk("event_count", 32'(ev_rel.size() >= 4), 1);
        if (ev_rel.size() >= 4) begin
            chk("pre_at", ev_rel[0], 9 * s);
            chk("pre_cmd", 32'(ev_cmd[0]), 32'(C_PRE));
            chk("pre_a10", 32'(ev_addr[0] >> 10) & 1, 1);
            chk("aref0_at", ev_rel[1], 11 * s);
            chk("aref0_cmd", 32'(ev_cmd[1]), 32'(C_AREF));
            chk("aref1_at", ev_rel[2], 15 * s);
            chk("lmr_at", ev_rel[3], 19 * s);
            chk("lmr_cmd", 32'(ev_cmd[3]), 32'(C_LMR));
            chk("lmr_addr", 32'(ev_addr[3]), 32'h033);
        end
        chk("fin_at", fin_rel, 21 * s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        ireset_n = 1'b1;

        // nominal, ireq held high to show it is ignored after acceptance
        start_run();
        run_until_fin(1'b0, 1'b1, 200);
        check_run(1);
        repeat (100) @(negedge clk);
`ifdef SDRAM_AUTO_REFRESH_EN
        chk("periodic_seen", 32'(ev_rel.size() >= 6), 1);
        if (ev_rel.size() >= 6) begin
            chk("ref0_at", ev_rel[4], 36);
            chk("ref_period", ev_rel[5] - ev_rel[4], 16);
        end
        chk("fin_held", 32'(ofin), 1);
`else
        chk("no_periodic", ev_rel.size(), 4);
        chk("refresh_tied", 32'(orefresh), 0);
`endif

        // idle hold, then one-cycle ireq pulse
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ienb = 1'($urandom_range(0, 1));
        end
        chk("idle_cke", 32'(cke), 0);
        chk("idle_fin", 32'(ofin), 0);
        chk("idle_cmd", 32'(dut_cmd), 32'(C_INH));
        start_run();
        run_until_fin(1'b0, 1'b0, 200);
        check_run(1);

        // ienb toggling every cycle doubles every interval
        do_reset();
        start_run();
        run_until_fin(1'b1, 1'b0, 200);
        check_run(2);

        // reset between the two init AREFs, then restart
        do_reset();
        start_run();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ireq = 1'b0; ienb = 1'b1;
        end
        @(negedge clk);
        ireset_n = 1'b0;
        @(negedge clk);
        ireset_n = 1'b1;
        chk("abort_cke", 32'(cke), 0);
        chk("abort_cmd", 32'(dut_cmd), 32'(C_INH));
        start_run();
        run_until_fin(1'b0, 1'b0, 200);
        check_run(1);

        // random enables, requests and occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ienb     = ($urandom_range(0, 3) != 0);
            ireq     = ($urandom_range(0, 7) == 0);
            ireset_n = ($urandom_range(0, 79) != 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_init_refresh.md
SDRAM_INIT_REFRESH -- requirements
Module: sdram_init_refresh

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- T_PWRUP, 10000, power-up wait in enabled cycles (>=1).
- T_RP, 3, precharge-to-command spacing (>=1).
- T_RFC, 9, auto-refresh-to-command spacing (>=1).
- T_MRD, 2, load-mode-register-to-done spacing (>=1).
- N_AREF, 2, number of init auto-refreshes (1..8).
- CAS_LAT, 3, CAS latency code (2 or 3).
- BL_CODE, 3, burst length code (0..3 -> 1/2/4/8).
- REF_INTERVAL, 780, periodic refresh period in enabled cycles (>T_RFC).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- iclk, in, 1, the only clock; all logic updates on its rising edge.
- ireset_n, in, 1, synchronous, active-low reset.
- ireq, in, 1, request to start initialization.
- ienb, in, 1, step enable; the sequencer advances only when it is 1.
- ofin, out, 1, initialization complete.
- orefresh, out, 1, periodic refresh in progress.
- DRAM_CKE, out, 1, clock enable.
- DRAM_ADDR, out, 13, address / mode word.
- DRAM_BA, out, 2, bank select.
- DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, out, 1 each, command strobes.
- DRAM_LDQM, DRAM_UDQM, out, 1 each, byte masks.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 Commands {CS,RAS,CAS,WE} SHALL be encoded as: INHIBIT=1111, NOP=0111, PRECHARGE=0010, AREF=0001, LMR=0000.
REQ-005 The FSM states SHALL be IDLE, WAIT_PWR, PRECH, WAIT_RP, AREF, WAIT_RFC, LMR, WAIT_MRD, DONE.
REQ-006 In IDLE the block SHALL output INHIBIT with CKE=0, and SHALL move to WAIT_PWR on the first edge where ireq=1 and ienb=1.
REQ-007 WAIT_PWR SHALL hold CKE=1 and output NOP for T_PWRUP enabled cycles, then go to PRECH.
REQ-008 PRECH SHALL issue PRECHARGE for one cycle with DRAM_ADDR[10]=1 (all banks), followed by T_RP-1 NOP cycles.
REQ-009 The block SHALL issue N_AREF AREF commands, each followed by T_RFC-1 NOP cycles; a 3-bit counter SHALL track them.
REQ-010 LMR SHALL issue for one cycle with DRAM_BA=0 and DRAM_ADDR={3'b0, 1'b0 (A9, burst write), 2'b00, CAS_LAT[2:0], 1'b0 (sequential), BL_CODE[2:0]}, followed by T_MRD-1 NOP cycles, then go to DONE.
REQ-011 Consequently, with ienb held at 1, ofin SHALL rise exactly 1+T_PWRUP+T_RP+N_AREF*T_RFC+T_MRD cycles after the edge that accepted ireq.
REQ-012 ofin SHALL stay 1 in DONE until reset, and ireq SHALL be ignored outside IDLE.
REQ-013 When ienb=0, the state and all counters SHALL freeze, and the command outputs SHALL be NOP (INHIBIT in IDLE); a command therefore issues only on an enabled cycle.
REQ-014 DRAM_LDQM and DRAM_UDQM SHALL be 1 in every state, and DRAM_ADDR and DRAM_BA SHALL be 0 except as stated above.
REQ-015 Wait counters SHALL be sized to $clog2 of the largest timing parameter plus 1, and SHALL NOT wrap.

Reset
REQ-016 While ireset_n=0 at an edge, the block SHALL enter IDLE, clear all counters, and set ofin=0, orefresh=0, CKE=0, command=INHIBIT, ADDR=0, BA=0, and DQM=11.
REQ-017 Reset asserted mid-sequence or in DONE SHALL abort immediately, and a new ireq SHALL restart from WAIT_PWR.

Configuration
REQ-018 With the macro SDRAM_AUTO_REFRESH_EN defined, DONE SHALL run an interval counter from 0 on DONE entry.
REQ-019 With SDRAM_AUTO_REFRESH_EN defined, when the counter reaches REF_INTERVAL-1 the block SHALL issue AREF on the next enabled cycle, hold orefresh=1 for that cycle plus T_RFC-1 NOP cycles, and restart the counter at the AREF cycle.
REQ-020 With SDRAM_AUTO_REFRESH_EN defined, ofin SHALL remain 1 during periodic refreshes.
REQ-021 Without SDRAM_AUTO_REFRESH_EN, DONE SHALL output NOP indefinitely, and orefresh SHALL be tied to 0.

Verification
Bench parameters: T_PWRUP=8, T_RP=2, T_RFC=4, T_MRD=2, N_AREF=2, CAS_LAT=3, BL_CODE=3, REF_INTERVAL=16.
REQ-022 Nominal: reset low for 2 edges, then ireq=1 and ienb=1 -> CKE=1 next cycle; PRECHARGE with ADDR[10]=1 at accept+9; AREF at +11 and +15; LMR at +19 with ADDR=0x033; ofin=1 at +21.
REQ-023 ienb toggling every cycle -> the same command order, with every interval doubled; ofin=1 at accept+42; no command issues on a cycle where ienb=0.
REQ-024 ireq=0 for 50 cycles after reset -> the block stays in IDLE with INHIBIT, CKE=0 and ofin=0; pulsing ireq=1 for 1 cycle then starts the sequence.
REQ-025 ireset_n=0 for 1 edge at accept+13 (between AREFs) -> all outputs return to their reset values; a new ireq reproduces the REQ-022 timing.
REQ-026 With SDRAM_AUTO_REFRESH_EN, after ofin -> AREF every 16 cycles with orefresh=1 for 4 cycles and ofin held at 1; without the macro -> NOP only and orefresh=0 for 100 cycles.
